tcm_conf_arbiter: RTL and testbench

TCM_CONF_ARBITER -- requirements
Module: tcm_conf_arbiter

---
 rtl/tcm_conf_arbiter_pkg.sv | 14 +
 rtl/tcm_conf_arbiter_rd_tracker.sv | 43 ++++
 rtl/tcm_conf_arbiter.sv | 166 ++++++++++++++++
 tb/tb_tcm_conf_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_conf_arbiter_pkg.sv
// Shared types for the TCM configuration arbiter: FSM encoding and master ids.
// Burst locking is compiled in by defining TCM_ARB_LOCK_EN.
package tcm_conf_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/tcm_conf_arbiter_rd_tracker.sv
// Read-return tracker: RD_LAT-deep shift of {valid, master id}, fed by the
// registered TCM read strobe so the last stage lines up with conf_rdata.
module tcm_rd_tracker #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push_valid,
    input  logic push_id,
    output logic pop_valid,
    output logic pop_id
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [RD_LAT-1:0] id_q;
    logic [RD_LAT-1:0] id_d;

    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        vld_d[0] = push_valid;
        id_d[0]  = push_valid & push_id;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign pop_valid = vld_q[RD_LAT-1];
    assign pop_id    = id_q[RD_LAT-1];

endmodule

// File: rtl/tcm_conf_arbiter.sv
// Two-master round-robin arbiter in front of the configuration TCM.
// Define TCM_ARB_LOCK_EN to let mX_lock hold the grant across a burst.
module tcm_conf_arbiter
    import tcm_conf_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              conf_rden,
    output logic              conf_wren,
    output logic [ADDR_W-1:0] conf_addr,
    output logic [DATA_W-1:0] conf_wdata,
    input  logic [DATA_W-1:0] conf_rdata
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic              rd_id_q, rd_id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gnt_any;
    logic              gnt_id;
    logic              gnt_we;
    logic              pop_valid;
    logic              pop_id;

`ifndef TCM_ARB_LOCK_EN
    logic lock_unused;
    assign lock_unused = m0_lock | m1_lock;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= M1;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            rd_id_q  <= M0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rden_q   <= rden_d;
            wren_q   <= wren_d;
            rd_id_q  <= rd_id_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Ownership ends on an unlocked accepted beat or as soon as req drops.
    always_comb begin
        state_d = IDLE;
`ifdef TCM_ARB_LOCK_EN
        unique case (state_q)
            IDLE: begin
                if (m0_gnt && m0_lock) begin
                    state_d = OWN0;
                end else if (m1_gnt && m1_lock) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (m0_req && !(m0_gnt && !m0_lock)) begin
                    state_d = OWN0;
                end
            end
            OWN1: begin
                if (m1_req && !(m1_gnt && !m1_lock)) begin
                    state_d = OWN1;
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        unique case (state_q)
            OWN0: m0_gnt = m0_req;
            OWN1: m1_gnt = m1_req;
            default: begin
                if (m0_req && m1_req) begin
                    m0_gnt = (last_q == M1);
                    m1_gnt = (last_q == M0);
                end else begin
                    m0_gnt = m0_req;
                    m1_gnt = m1_req;
                end
            end
        endcase
    end

    always_comb begin
        gnt_any = m0_gnt | m1_gnt;
        gnt_id  = m1_gnt ? M1 : M0;
        gnt_we  = m1_gnt ? m1_we : m0_we;
        last_d  = gnt_any ? gnt_id : last_q;
        rden_d  = gnt_any & ~gnt_we;
        wren_d  = gnt_any & gnt_we;
        rd_id_d = gnt_any ? gnt_id : rd_id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (gnt_any) begin
            addr_d  = m1_gnt ? m1_addr : m0_addr;
            wdata_d = m1_gnt ? m1_wdata : m0_wdata;
        end
    end

    tcm_rd_tracker #(
        .RD_LAT(RD_LAT)
    ) u_rd_tracker (
        .clk       (clk),
        .reset     (reset),
        .push_valid(rden_q),
        .push_id   (rd_id_q),
        .pop_valid (pop_valid),
        .pop_id    (pop_id)
    );

    // Returning data passes straight through; the flop only remembers it.
    always_comb begin
        m0_rvalid = pop_valid & (pop_id == M0);
        m1_rvalid = pop_valid & (pop_id == M1);
        m0_rdata  = m0_rvalid ? conf_rdata : rdata0_q;
        m1_rdata  = m1_rvalid ? conf_rdata : rdata1_q;
        rdata0_d  = m0_rdata;
        rdata1_d  = m1_rdata;
    end

    assign conf_rden  = rden_q;
    assign conf_wren  = wren_q;
    assign conf_addr  = addr_q;
    assign conf_wdata = wdata_q;

endmodule

// File: tb/tb_tcm_conf_arbiter.sv
// Self-checking bench for tcm_conf_arbiter: directed scenarios plus random
// traffic against a transaction-level model with a queue of pending reads.
module tb_tcm_conf_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [31:0] conf_rdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        conf_rden, conf_wren;
    logic [31:0] conf_addr, conf_wdata;

    always #5 clk = ~clk;

    tcm_conf_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .conf_rden (conf_rden),
        .conf_wren (conf_wren),
        .conf_addr (conf_addr),
        .conf_wdata(conf_wdata),
        .conf_rdata(conf_rdata)
    );

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rd_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    rd_t         rq[$];
    int          last_m;
    int          owner;
    logic [31:0] exp_addr, exp_wdata;
    logic [31:0] hold [2];
    logic        prev_rd, prev_wr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        rq.delete();
        last_m    = 1;
        owner     = -1;
        exp_addr  = '0;
        exp_wdata = '0;
        hold[0]   = '0;
        hold[1]   = '0;
        prev_rd   = 1'b0;
        prev_wr   = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        m0_req     = 1'b0;
        m1_req     = 1'b0;
        conf_rdata = $urandom;
        reset      = 1'b1;
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_rden", 32'(conf_rden), 32'h0);
        chk("rst_wren", 32'(conf_wren), 32'h0);
        chk("rst_addr", conf_addr, 32'h0);
        chk("rst_wdata", conf_wdata, 32'h0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        repeat (n) @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] we,
                        input logic [1:0] lk,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic [31:0] rdat,
                        output logic [1:0] g_obs);
        logic [1:0]  g;
        logic [1:0]  rv;
        logic [31:0] addr [2];
        logic [31:0] wd [2];
        rd_t         ent;
        addr[0] = a0;
        addr[1] = a1;
        wd[0]   = d0;
        wd[1]   = d1;
        @(negedge clk);
        m0_req   = req[0];
        m0_we    = we[0];
        m0_lock  = lk[0];
        m0_addr  = a0;
        m0_wdata = d0;
        m1_req   = req[1];
        m1_we    = we[1];
        m1_lock  = lk[1];
        m1_addr  = a1;
        m1_wdata = d1;
        rv = 2'b00;
        conf_rdata = $urandom;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ent = rq.pop_front();
            rv[ent.id] = 1'b1;
            conf_rdata = ent.data;
            hold[ent.id] = ent.data;
        end
        #1;
        g = 2'b00;
        if (owner >= 0) g[owner] = req[owner];
        else if (req == 2'b11) g[1-last_m] = 1'b1;
        else g = req;
        chk("m0_gnt", 32'(m0_gnt), 32'(g[0]));
        chk("m1_gnt", 32'(m1_gnt), 32'(g[1]));
        chk("conf_rden", 32'(conf_rden), 32'(prev_rd));
        chk("conf_wren", 32'(conf_wren), 32'(prev_wr));
        chk("conf_addr", conf_addr, exp_addr);
        chk("conf_wdata", conf_wdata, exp_wdata);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(rv[0]));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(rv[1]));
        chk("m0_rdata", m0_rdata, hold[0]);
        chk("m1_rdata", m1_rdata, hold[1]);
        g_obs = {m1_gnt, m0_gnt};
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (g[m]) begin
                last_m    = m;
                exp_addr  = addr[m];
                exp_wdata = wd[m];
                if (we[m]) begin
                    prev_wr = 1'b1;
                end else begin
                    prev_rd  = 1'b1;
                    ent.due  = cyc + RD_LAT + 1;
                    ent.id   = m;
                    ent.data = rdat;
                    rq.push_back(ent);
                end
            end
        end
`ifdef TCM_ARB_LOCK_EN
        if (owner >= 0) begin
            if (!req[owner] || (g[owner] && !lk[owner])) owner = -1;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (g[m] && lk[m]) owner = m;
            end
        end
`endif
        cyc++;
    endtask

    task automatic idle(input int n);
        logic [1:0] gd;
        repeat (n) begin
            step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h0, gd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  g;
        logic [1:0]  r, w, l;
        int          beats;
        int          m1cnt;

        model_clear();
        do_reset(2);

        // single m0 write
        step(2'b01, 2'b01, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0,
             32'h0, g);
        chk("wr_m0_gnt", 32'(g), 32'h1);
        idle(RD_LAT + 2);

        // both masters reading every cycle
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            step(2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h100, 32'h0,
                 $urandom, g);
            chk("rr_alt", 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        idle(RD_LAT + 2);

        // back-to-back reads with fixed TCM data
        do_reset(1);
        step(2'b01, 2'b00, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0,
             32'h11, g);
        step(2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h8, 32'h0,
             32'h22, g);
        idle(RD_LAT + 2);
        chk("b2b_m0_rdata", m0_rdata, 32'h11);
        chk("b2b_m1_rdata", m1_rdata, 32'h22);

        // m0 locked burst while m1 keeps requesting
        do_reset(1);
        beats = 0;
        m1cnt = 0;
        for (int i = 0; i < 20 && beats < 4; i++) begin
            l = {1'b0, beats < 3};
            step(2'b11, 2'b11, l, 32'h40 + 32'(beats), $urandom,
                 32'h80, $urandom, 32'h0, g);
            if (g[0]) beats++;
            if (g[1]) m1cnt++;
        end
        chk("burst_beats", 32'(beats), 32'h4);
`ifdef TCM_ARB_LOCK_EN
        chk("burst_m1_held", 32'(m1cnt), 32'h0);
`else
        chk("burst_m1_interleave", 32'(m1cnt), 32'h3);
`endif
        step(2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'h80, 32'h5,
             32'h0, g);
        chk("burst_m1_after", 32'(g), 32'h2);

        // reset with an m1 read in flight
        step(2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h20, 32'h0,
             32'hBAD, g);
        do_reset(2);
        idle(RD_LAT + 3);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset(1);
            r = 2'($urandom_range(0, 3));
            w = 2'($urandom_range(0, 3));
            l = 2'($urandom_range(0, 3));
            step(r, w, l, $urandom, $urandom, $urandom, $urandom,
                 $urandom, g);
        end
        idle(RD_LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
